// File: rtl/cpu_issue_pkg.sv
// Shared issue-stage types and constants for the 4-slot bundle.
// Slot order A0, A1, M, LS; source order A0R0..LSR2.
package cpu_issue_pkg;

    typedef enum logic [1:0] {
        SLOT_A0,
        SLOT_A1,
        SLOT_M,
        SLOT_LS
    } slot_e;

    localparam int NUM_SLOTS = 4;
    localparam int NUM_SRC   = 9;
    localparam int TAG_W     = 5;
    localparam int DATA_W    = 16;

    localparam int DEF_ALU_LAT = 1;
    localparam int DEF_M_LAT   = 2;
    localparam int DEF_LS_LAT  = 2;

    localparam slot_e SRC_SLOT [NUM_SRC] = '{
        SLOT_A0, SLOT_A0,
        SLOT_A1, SLOT_A1,
        SLOT_M,  SLOT_M,
        SLOT_LS, SLOT_LS, SLOT_LS
    };

endpackage

// File: rtl/sb_pend_cnt.sv
// Per-register pending counter: cycles left until the result is forwardable.
// Ports: clk, rst_n, hold, load, value in; count out.
module sb_pend_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (hold) begin
            count <= count;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage RAW/WAW interlock for the A0/A1/M/LS bundle with stall counter.
// Ports: bundle tags/enables in; issue_go/stall, hazard causes, busy, stall_cnt out.
module hazard_scoreboard
    import cpu_issue_pkg::*;
#(
    parameter int ALU_LAT = DEF_ALU_LAT,
    parameter int M_LAT   = DEF_M_LAT,
    parameter int LS_LAT  = DEF_LS_LAT,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        pipe_hold,
    input  logic [44:0] src_tag,
    input  logic [8:0]  src_use,
    input  logic [19:0] dst_tag,
    input  logic [3:0]  dst_we,
    output logic        issue_go,
    output logic        issue_stall,
    output logic [8:0]  raw_hazard,
    output logic [3:0]  waw_hazard,
    output logic        dst_conflict,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    // Value loaded on issue: the result becomes forwardable when it hits 0.
    localparam logic [CNT_W-1:0] LM1 [NUM_SLOTS] = '{
        CNT_W'(ALU_LAT - 1),
        CNT_W'(ALU_LAT - 1),
        CNT_W'(M_LAT - 1),
        CNT_W'(LS_LAT - 1)
    };

    logic [CNT_W-1:0] cnt [32];
    logic [8:0]       raw;
    logic [3:0]       waw;
    logic             conf;
    logic             act;

    // Gating with rst_n keeps every decision output low during reset.
    assign act = id_valid & rst_n;
    assign cnt[0] = '0;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_raw
        logic [TAG_W-1:0] t;
        assign t = src_tag[i*TAG_W +: TAG_W];
        assign raw[i] = src_use[i] && (t != '0) && (cnt[t] != '0);
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_waw
        logic [TAG_W-1:0] t;
        assign t = dst_tag[s*TAG_W +: TAG_W];
        assign waw[s] = dst_we[s] && (t != '0) && (cnt[t] > LM1[s]);
    end

    always_comb begin
        conf = 1'b0;
        for (int a = 0; a < NUM_SLOTS; a++) begin
            for (int b = a + 1; b < NUM_SLOTS; b++) begin
                if (dst_we[a] && dst_we[b] &&
                    dst_tag[a*TAG_W +: TAG_W] != '0 &&
                    dst_tag[a*TAG_W +: TAG_W] == dst_tag[b*TAG_W +: TAG_W])
                    conf = 1'b1;
            end
        end
    end

    assign raw_hazard   = raw & {9{act}};
    assign waw_hazard   = waw & {4{act}};
    assign dst_conflict = conf & act;
    assign issue_go     = act & ~pipe_hold & ~|raw & ~|waw & ~conf;
    assign issue_stall  = act & ~issue_go;

    for (genvar r = 1; r < 32; r++) begin : g_reg
        logic             ld;
        logic [CNT_W-1:0] val;

        // At most one slot matches: conflicting bundles never issue.
        always_comb begin
            ld  = 1'b0;
            val = '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (dst_we[s] && dst_tag[s*TAG_W +: TAG_W] == TAG_W'(r)) begin
                    ld  = 1'b1;
                    val = LM1[s];
                end
            end
        end

        sb_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .hold  (pipe_hold),
            .load  (issue_go & ld),
            .value (val),
            .count (cnt[r])
        );
    end

    always_comb begin
        busy = 1'b0;
        for (int r = 1; r < 32; r++) begin
            if (cnt[r] != '0)
                busy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (issue_stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (M_LAT=3 build).
// Drives bundles after posedge, checks at negedge.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        pipe_hold;
    logic [44:0] src_tag;
    logic [8:0]  src_use;
    logic [19:0] dst_tag;
    logic [3:0]  dst_we;
    logic        issue_go;
    logic        issue_stall;
    logic [8:0]  raw_hazard;
    logic [3:0]  waw_hazard;
    logic        dst_conflict;
    logic        busy;
    logic [15:0] stall_cnt;

    int vectors = 0;
    int errors  = 0;
    int exp_sc  = 0;

    hazard_scoreboard #(
        .ALU_LAT (1),
        .M_LAT   (3),
        .LS_LAT  (2),
        .CNT_W   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .pipe_hold    (pipe_hold),
        .src_tag      (src_tag),
        .src_use      (src_use),
        .dst_tag      (dst_tag),
        .dst_we       (dst_we),
        .issue_go     (issue_go),
        .issue_stall  (issue_stall),
        .raw_hazard   (raw_hazard),
        .waw_hazard   (waw_hazard),
        .dst_conflict (dst_conflict),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic clear_in();
        id_valid  = 1'b0;
        pipe_hold = 1'b0;
        src_tag   = '0;
        src_use   = '0;
        dst_tag   = '0;
        dst_we    = '0;
    endtask

    task automatic set_src(input int idx, input logic [4:0] t);
        src_tag[idx*5 +: 5] = t;
        src_use[idx] = 1'b1;
    endtask

    task automatic set_dst(input int s, input logic [4:0] t);
        dst_tag[s*5 +: 5] = t;
        dst_we[s] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        clear_in();
        repeat (4) step();
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        id_valid = 1'b1;
        set_src(0, 5'd1);
        @(negedge clk);
        vectors++;
        if (issue_go !== 1'b0 || issue_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_issue: got go=%b stall=%b, want 0 0",
                     issue_go, issue_stall);
        end
        vectors++;
        if (busy !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b sc=%0d, want 0 0",
                     busy, stall_cnt);
        end
        step();
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_load_use();
        clear_in();
        id_valid = 1'b1;
        set_dst(3, 5'd5);
        @(negedge clk);
        vectors++;
        if (issue_go !== 1'b1) begin
            errors++;
            $display("FAIL lu_prod: got go=%b, want 1", issue_go);
        end
        step();
        clear_in();
        id_valid = 1'b1;
        set_src(0, 5'd5);
        @(negedge clk);
        vectors++;
        if (issue_stall !== 1'b1 || raw_hazard !== 9'h001) begin
            errors++;
            $display("FAIL lu_stall: got stall=%b raw=%h, want 1 001",
                     issue_stall, raw_hazard);
        end
        exp_sc++;
        step();
        @(negedge clk);
        vectors++;
        if (issue_go !== 1'b1 || stall_cnt !== 16'(exp_sc)) begin
            errors++;
            $display("FAIL lu_issue: got go=%b sc=%0d, want 1 %0d",
                     issue_go, stall_cnt, exp_sc);
        end
        step();
        drain();
    endtask

    task automatic test_alu_b2b();
        clear_in();
        id_valid = 1'b1;
        set_dst(0, 5'd7);
        @(negedge clk);
        vectors++;
        if (issue_go !== 1'b1) begin
            errors++;
            $display("FAIL alu_prod: got go=%b, want 1", issue_go);
        end
        step();
        clear_in();
        id_valid = 1'b1;
        set_src(3, 5'd7);
        @(negedge clk);
        vectors++;
        if (issue_go !== 1'b1 || raw_hazard !== 9'h000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL alu_cons: got go=%b raw=%h busy=%b, want 1 000 0",
                     issue_go, raw_hazard, busy);
        end
        step();
        clear_in();
        id_valid = 1'b1;
        set_dst(3, 5'd5);
        step();
        clear_in();
        id_valid = 1'b1;
        set_src(0, 5'd0);
        set_src(8, 5'd0);
        @(negedge clk);
        vectors++;
        if (issue_go !== 1'b1 || raw_hazard !== 9'h000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tag0: got go=%b raw=%h busy=%b, want 1 000 1",
                     issue_go, raw_hazard, busy);
        end
        step();
        clear_in();
        id_valid = 1'b1;
        set_dst(3, 5'd5);
        step();
        clear_in();
        set_src(0, 5'd5);
        @(negedge clk);
        vectors++;
        if (raw_hazard !== 9'h000 || issue_stall !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL novalid: got raw=%h stall=%b busy=%b, want 000 0 1",
                     raw_hazard, issue_stall, busy);
        end
        step();
        drain();
    endtask

    task automatic test_mul();
        clear_in();
        id_valid = 1'b1;
        set_dst(2, 5'd9);
        step();
        clear_in();
        id_valid = 1'b1;
        set_src(8, 5'd9);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (issue_stall !== 1'b1 || raw_hazard !== 9'h100 || busy !== 1'b1) begin
                errors++;
                $display("FAIL mul_stall%0d: got stall=%b raw=%h busy=%b, want 1 100 1",
                         c, issue_stall, raw_hazard, busy);
            end
            exp_sc++;
            step();
        end
        @(negedge clk);
        vectors++;
        if (issue_go !== 1'b1 || busy !== 1'b0 || stall_cnt !== 16'(exp_sc)) begin
            errors++;
            $display("FAIL mul_issue: got go=%b busy=%b sc=%0d, want 1 0 %0d",
                     issue_go, busy, stall_cnt, exp_sc);
        end
        step();
        drain();
    endtask

    task automatic test_waw();
        clear_in();
        id_valid = 1'b1;
        set_dst(3, 5'd4);
        step();
        clear_in();
        id_valid = 1'b1;
        set_dst(0, 5'd4);
        @(negedge clk);
        vectors++;
        if (waw_hazard !== 4'b0001 || issue_go !== 1'b0) begin
            errors++;
            $display("FAIL waw_stall: got waw=%b go=%b, want 0001 0",
                     waw_hazard, issue_go);
        end
        exp_sc++;
        step();
        @(negedge clk);
        vectors++;
        if (waw_hazard !== 4'b0000 || issue_go !== 1'b1) begin
            errors++;
            $display("FAIL waw_issue: got waw=%b go=%b, want 0000 1",
                     waw_hazard, issue_go);
        end
        step();
        clear_in();
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || stall_cnt !== 16'(exp_sc)) begin
            errors++;
            $display("FAIL waw_after: got busy=%b sc=%0d, want 0 %0d",
                     busy, stall_cnt, exp_sc);
        end
        drain();
    endtask

    task automatic test_hold();
        clear_in();
        id_valid = 1'b1;
        set_dst(3, 5'd6);
        step();
        clear_in();
        id_valid = 1'b1;
        pipe_hold = 1'b1;
        set_src(0, 5'd6);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (issue_stall !== 1'b1 || issue_go !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold%0d: got stall=%b go=%b busy=%b, want 1 0 1",
                         c, issue_stall, issue_go, busy);
            end
            exp_sc++;
            step();
        end
        pipe_hold = 1'b0;
        @(negedge clk);
        vectors++;
        if (issue_stall !== 1'b1 || raw_hazard !== 9'h001) begin
            errors++;
            $display("FAIL hold_rel: got stall=%b raw=%h, want 1 001",
                     issue_stall, raw_hazard);
        end
        exp_sc++;
        step();
        @(negedge clk);
        vectors++;
        if (issue_go !== 1'b1 || stall_cnt !== 16'(exp_sc)) begin
            errors++;
            $display("FAIL hold_issue: got go=%b sc=%0d, want 1 %0d",
                     issue_go, stall_cnt, exp_sc);
        end
        step();
        drain();
    endtask

    task automatic test_conflict();
        clear_in();
        id_valid = 1'b1;
        set_dst(0, 5'd12);
        set_dst(2, 5'd12);
        @(negedge clk);
        vectors++;
        if (dst_conflict !== 1'b1 || issue_go !== 1'b0 || issue_stall !== 1'b1) begin
            errors++;
            $display("FAIL conflict: got conf=%b go=%b stall=%b, want 1 0 1",
                     dst_conflict, issue_go, issue_stall);
        end
        exp_sc++;
        step();
        clear_in();
        id_valid = 1'b1;
        set_dst(0, 5'd0);
        set_dst(2, 5'd0);
        @(negedge clk);
        vectors++;
        if (dst_conflict !== 1'b0 || issue_go !== 1'b1 || stall_cnt !== 16'(exp_sc)) begin
            errors++;
            $display("FAIL conflict_r0: got conf=%b go=%b sc=%0d, want 0 1 %0d",
                     dst_conflict, issue_go, stall_cnt, exp_sc);
        end
        step();
        drain();
    endtask

    task automatic test_async_reset();
        clear_in();
        id_valid = 1'b1;
        set_dst(3, 5'd3);
        step();
        clear_in();
        id_valid = 1'b1;
        set_src(0, 5'd3);
        @(negedge clk);
        vectors++;
        if (raw_hazard !== 9'h001) begin
            errors++;
            $display("FAIL ar_pre: got raw=%h, want 001", raw_hazard);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_sc = 0;
        vectors++;
        if (busy !== 1'b0 || stall_cnt !== 16'd0 || raw_hazard !== 9'h000 ||
            issue_stall !== 1'b0) begin
            errors++;
            $display("FAIL ar_mid: got busy=%b sc=%0d raw=%h stall=%b, want 0 0 000 0",
                     busy, stall_cnt, raw_hazard, issue_stall);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (issue_go !== 1'b1 || raw_hazard !== 9'h000) begin
            errors++;
            $display("FAIL ar_first: got go=%b raw=%h, want 1 000",
                     issue_go, raw_hazard);
        end
        step();
        clear_in();
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL ar_sc: got sc=%0d, want 0", stall_cnt);
        end
        drain();
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_alu_b2b();
        test_mul();
        test_waw();
        test_hold();
        test_conflict();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
